// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and control-FSM state encodings for the commit trace buffer.
package commit_trace_buffer_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [31:0] instr_t;
  typedef logic [4:0]  fsm_state_t;

  // Control FSM state encodings, shared with the control FSM and the logger.
  localparam fsm_state_t FETCH      = 5'b00000;
  localparam fsm_state_t DECODE     = 5'b00001;
  localparam fsm_state_t MEMADR     = 5'b00010;
  localparam fsm_state_t MEMREAD    = 5'b00011;
  localparam fsm_state_t MEMWB      = 5'b00100;
  localparam fsm_state_t MEMWRITE   = 5'b00101;
  localparam fsm_state_t EXECUTER   = 5'b00110;
  localparam fsm_state_t EXECUTEI   = 5'b00111;
  localparam fsm_state_t ALUWB      = 5'b01000;
  localparam fsm_state_t BRANCH     = 5'b01001;
  localparam fsm_state_t JAL        = 5'b01010;
  localparam fsm_state_t FETCH_WAIT = 5'b10000;

  // One record per retired instruction.
  typedef struct packed {
    addr_t       pc;
    instr_t      instr;
    logic [4:0]  rd;
    data_t       rd_wdata;
    logic        rd_we;
    addr_t       mem_addr;
    data_t       mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] seq;
  } trace_record_t;

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Generic show-ahead synchronous FIFO; level is derived from extra-bit counters.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_cnt - rd_cnt;
  assign empty   = (wr_cnt == rd_cnt);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A pop at the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_cnt[AW-1:0]];

  // Read/write counters; pointers are their low bits and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement tracer: stages per-instruction state, emits one record per retire.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             fsm_state,
  input  logic [31:0]            pc_cur,
  input  logic [31:0]            instruction,
  input  logic [4:0]             rd,
  input  logic [31:0]            result,
  input  logic                   reg_write,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [3:0]             mem_we,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output trace_record_t          trace_rec,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       drop_count,
  output logic [31:0]            retire_count
);

  localparam int unsigned RW = $bits(trace_record_t);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]    prev_state_q;
  logic          armed_q;
  addr_t         st_pc;
  instr_t        st_instr;
  logic [4:0]    st_rd;
  data_t         st_rd_wdata;
  logic          st_rd_we;
  addr_t         st_mem_addr;
  data_t         st_mem_wdata;
  logic [3:0]    st_mem_be;

  logic          retire;
  logic          pop;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  trace_record_t push_rec;
  logic [RW-1:0] head_bits;
  trace_record_t head_rec;

  assign retire = (fsm_state == FETCH) && (prev_state_q != FETCH) &&
                  (prev_state_q != FETCH_WAIT) && armed_q;
  assign pop    = trace_valid && trace_ready;
  assign push   = retire && (!fifo_full || pop);

  // Track previous FSM state and whether an instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state_q <= FETCH;
      armed_q      <= 1'b0;
    end else begin
      prev_state_q <= fsm_state;
      if (fsm_state == DECODE) armed_q <= 1'b1;
      else if (retire)         armed_q <= 1'b0;
    end
  end

  // Stage PC/instruction at DECODE and the last reg/mem write of the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_pc        <= '0;
      st_instr     <= '0;
      st_rd        <= '0;
      st_rd_wdata  <= '0;
      st_rd_we     <= 1'b0;
      st_mem_addr  <= '0;
      st_mem_wdata <= '0;
      st_mem_be    <= '0;
    end else begin
      if (fsm_state == DECODE) begin
        st_pc     <= pc_cur;
        st_instr  <= instruction;
        st_rd_we  <= 1'b0;
        st_mem_be <= '0;
      end
      if (reg_write && (rd != 5'd0)) begin
        st_rd       <= rd;
        st_rd_wdata <= result;
        st_rd_we    <= 1'b1;
      end
      if (mem_we != 4'd0) begin
        st_mem_addr  <= mem_addr;
        st_mem_wdata <= mem_wdata;
        st_mem_be    <= mem_we;
      end
    end
  end

  // Assemble the record pushed on retire; seq is the pre-increment retire count.
  always_comb begin
    push_rec           = '0;
    push_rec.pc        = st_pc;
    push_rec.instr     = st_instr;
    push_rec.rd        = st_rd;
    push_rec.rd_wdata  = st_rd_wdata;
    push_rec.rd_we     = st_rd_we;
    push_rec.mem_addr  = st_mem_addr;
    push_rec.mem_wdata = st_mem_wdata;
    push_rec.mem_be    = st_mem_be;
    push_rec.seq       = retire_count;
  end

  // Retire and saturating drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
      drop_count   <= '0;
    end else if (retire) begin
      retire_count <= retire_count + 32'd1;
      if (!push && (drop_count != '1)) drop_count <= drop_count + CNT_ONE;
    end
  end

  trace_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_rec),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head_rec    = trace_record_t'(head_bits);
  assign trace_valid = !fifo_empty;
  assign trace_rec   = trace_valid ? head_rec : '0;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed plan plus random instruction streams.
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [4:0]    fsm_state;
  logic [31:0]   pc_cur;
  logic [31:0]   instruction;
  logic [4:0]    rd;
  logic [31:0]   result;
  logic          reg_write;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_we;
  logic          trace_valid;
  logic          trace_ready;
  trace_record_t trace_rec;
  logic [2:0]    fifo_level;
  logic [15:0]   drop_count;
  logic [31:0]   retire_count;

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fsm_state    (fsm_state),
    .pc_cur       (pc_cur),
    .instruction  (instruction),
    .rd           (rd),
    .result       (result),
    .reg_write    (reg_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_rec    (trace_rec),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of records the consumer should see, plus counters.
  trace_record_t mq[$];
  trace_record_t cur;
  logic [31:0]   m_retire;
  logic [15:0]   m_drop;
  bit            rdy_rand;
  logic          rdy_val;
  int            vectors;
  int            miscompares;

  logic [4:0] ex_states [9] = '{EXECUTER, EXECUTEI, ALUWB, MEMADR, MEMWRITE,
                               MEMREAD, MEMWB, BRANCH, JAL};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    trace_record_t e;
    e = '0;
    if (mq.size() != 0) e = mq[0];
    check("trace_valid", trace_valid, (mq.size() != 0));
    check("trace_rec", trace_rec, e);
    check("fifo_level", fifo_level, mq.size());
    check("drop_count", drop_count, m_drop);
    check("retire_count", retire_count, m_retire);
  endtask

  // One clock: check current outputs, take the edge, advance the model.
  task automatic tick(input bit ret);
    trace_record_t r;
    bit popped;
    trace_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    check_outputs();
    @(posedge clk);
    popped = (mq.size() != 0) && trace_ready;
    if (popped) void'(mq.pop_front());
    if (ret) begin
      r = cur;
      r.seq = m_retire;
      m_retire = m_retire + 32'd1;
      if (mq.size() < DEPTH) mq.push_back(r);
      else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] st);
    fsm_state   = st;
    reg_write   = 1'b0;
    mem_we      = 4'd0;
    rd          = 5'($urandom);
    result      = $urandom;
    mem_addr    = $urandom;
    mem_wdata   = $urandom;
    pc_cur      = $urandom;
    instruction = $urandom;
  endtask

  task automatic begin_instr(input logic [31:0] pc, input logic [31:0] ins);
    idle(DECODE);
    pc_cur      = pc;
    instruction = ins;
    cur.pc      = pc;
    cur.instr   = ins;
    cur.rd_we   = 1'b0;
    cur.mem_be  = 4'd0;
    tick(1'b0);
  endtask

  task automatic exec(input logic [4:0] st, input logic rw, input logic [4:0] r,
                      input logic [31:0] res, input logic [3:0] mwe,
                      input logic [31:0] ma, input logic [31:0] md);
    idle(st);
    reg_write = rw;
    rd        = r;
    result    = res;
    mem_we    = mwe;
    mem_addr  = ma;
    mem_wdata = md;
    if (rw && (r != 5'd0)) begin
      cur.rd       = r;
      cur.rd_wdata = res;
      cur.rd_we    = 1'b1;
    end
    if (mwe != 4'd0) begin
      cur.mem_addr  = ma;
      cur.mem_wdata = md;
      cur.mem_be    = mwe;
    end
    tick(1'b0);
  endtask

  task automatic retire_instr();
    idle(FETCH);
    tick(1'b1);
  endtask

  task automatic do_reset();
    idle(FETCH);
    rst_n = 1'b0;
    #1;
    mq.delete();
    cur      = '0;
    m_retire = '0;
    m_drop   = '0;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      idle(($urandom_range(0, 1) != 0) ? FETCH : FETCH_WAIT);
      tick(1'b0);
    end
  endtask

  task automatic random_instr();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      idle(($urandom_range(0, 1) != 0) ? FETCH : FETCH_WAIT);
      tick(1'b0);
    end
    begin_instr($urandom, $urandom);
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      exec(ex_states[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), 5'($urandom),
           $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
           $urandom, $urandom);
    end
    retire_instr();
  endtask

  initial begin
    trace_record_t t1;
    logic [15:0]   d0;
    vectors     = 0;
    miscompares = 0;
    cur         = '0;
    m_retire    = '0;
    m_drop      = '0;
    rdy_rand    = 1'b0;
    rdy_val     = 1'b1;
    trace_ready = 1'b1;
    rst_n       = 1'b0;
    idle(FETCH);
    #2;
    do_reset();

    // addi x5,x0,7 at 0x10 with consumer ready.
    begin_instr(32'h10, 32'h00700293);
    exec(EXECUTEI, 1'b0, 5'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    exec(ALUWB, 1'b1, 5'd5, 32'd7, 4'd0, 32'd0, 32'd0);
    retire_instr();
    t1 = '{pc: 32'h10, instr: 32'h00700293, rd: 5'd5, rd_wdata: 32'd7, rd_we: 1'b1,
           mem_addr: 32'd0, mem_wdata: 32'd0, mem_be: 4'd0, seq: 32'd0};
    check("t1_record", trace_rec, t1);
    idle(FETCH_WAIT);
    tick(1'b0);
    check("t1_valid_one_cycle", trace_valid, 1'b0);

    // sw: store record, no register write.
    begin_instr(32'h14, 32'h0051a023);
    exec(MEMADR, 1'b0, 5'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    exec(MEMWRITE, 1'b0, 5'd0, 32'd0, 4'hF, 32'h100, 32'hDEADBEEF);
    retire_instr();
    check("t2_rd_we", trace_rec.rd_we, 1'b0);
    check("t2_mem_be", trace_rec.mem_be, 4'hF);
    check("t2_mem_addr", trace_rec.mem_addr, 32'h100);
    check("t2_mem_wdata", trace_rec.mem_wdata, 32'hDEADBEEF);

    // Write to x0 is ignored; back-to-back FETCH/FETCH_WAIT never retire.
    begin_instr(32'h18, 32'h05500013);
    exec(ALUWB, 1'b1, 5'd0, 32'h55, 4'd0, 32'd0, 32'd0);
    retire_instr();
    check("t6_rd_we_x0", trace_rec.rd_we, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle((i % 2 == 0) ? FETCH : FETCH_WAIT);
      tick(1'b0);
    end
    check("t6_no_spurious", retire_count, 32'd3);

    // Reset mid-instruction discards it; FETCH without DECODE yields nothing.
    begin_instr(32'h1C, 32'h002081b3);
    exec(EXECUTER, 1'b1, 5'd3, 32'h1234, 4'd0, 32'd0, 32'd0);
    do_reset();
    exec(EXECUTER, 1'b0, 5'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    idle(FETCH);
    tick(1'b0);
    check("t5_no_record", trace_valid, 1'b0);
    begin_instr(32'h20, 32'h00100093);
    exec(ALUWB, 1'b1, 5'd1, 32'd1, 4'd0, 32'd0, 32'd0);
    retire_instr();
    check("t5_seq0", trace_rec.seq, 32'd0);

    // Overflow: six retirements into a 4-deep FIFO with no consumer.
    do_reset();
    rdy_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      begin_instr(32'h100 + 32'(4 * i), 32'h00000013 + 32'(i));
      exec(ALUWB, 1'b1, 5'(i + 1), 32'(i * 11), 4'd0, 32'd0, 32'd0);
      retire_instr();
    end
    check("t3_level", fifo_level, 3'd4);
    check("t3_drop", drop_count, 16'd2);
    check("t3_retire", retire_count, 32'd6);
    rdy_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_seq", trace_rec.seq, 32'(i));
      idle(FETCH_WAIT);
      tick(1'b0);
    end
    check("t3_empty", trace_valid, 1'b0);

    // Full FIFO: a retire coinciding with a pop still pushes.
    rdy_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      begin_instr(32'h200 + 32'(4 * i), $urandom);
      retire_instr();
    end
    d0 = drop_count;
    begin_instr(32'h300, 32'h00000033);
    exec(EXECUTER, 1'b0, 5'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    rdy_val = 1'b1;
    retire_instr();
    check("t4_level", fifo_level, 3'd4);
    check("t4_drop", drop_count, d0);
    drain();
    check("t4_drained", fifo_level, 3'd0);

    // Random instruction streams with varying consumer behaviour.
    for (int blk = 0; blk < 6; blk++) begin
      rdy_rand = (blk % 3) != 2;
      rdy_val  = 1'b0;
      for (int i = 0; i < 25; i++) random_instr();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retirement tracer for the multi-cycle RISC-V core.
- Watches the control FSM state, PC, instruction, register-file writes and data-memory writes, and assembles one record per retired instruction.
- Buffers records in a FIFO and streams them out over a valid/ready interface to the simulation logger or an on-chip debug drain.
- Counts retired and dropped instructions.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- fsm_state  in  5  control FSM state; FETCH=5'b00000, DECODE=5'b00001, FETCH_WAIT=5'b10000
- pc_cur  in  32  address of the executing instruction, valid from DECODE until the next FETCH
- instruction  in  32  instruction register
- rd  in  5  destination register index
- result  in  32  register-file write data
- reg_write  in  1  register-file write enable
- mem_addr  in  32  data-memory address
- mem_wdata  in  32  data-memory write data
- mem_we  in  4  byte write strobes
- trace_valid  out  1  head record available
- trace_ready  in  1  consumer accepts head record
- trace_rec  out  trace_record_t  head record
- fifo_level  out  $clog2(DEPTH)+1  occupied entries
- drop_count  out  CNT_W  records dropped on overflow, saturating
- retire_count  out  32  instructions retired, wrapping

Behaviour:

Reset:
- All outputs 0; FIFO empty; prev_state_q = FETCH; armed = 0; staging record cleared.
- Reset mid-instruction discards the partial record.

Staging, every edge with rst_n high:
- fsm_state == DECODE: latch pc_cur and instruction; clear rd_we and mem_be; armed <= 1.
- reg_write && rd != 0: latch rd and result; rd_we <= 1. Writes to x0 are ignored.
- mem_we != 0: latch mem_addr, mem_wdata, mem_we. If several writes occur in one instruction, the last one wins.

Retire event at edge E:
- Condition: fsm_state == FETCH, prev_state_q not in {FETCH, FETCH_WAIT}, and armed.
- prev_state_q <= fsm_state every edge.

On retire:
- Record is {staged fields, seq = retire_count}.
- retire_count++ (wraps at 2^32); armed <= 0.
- If the FIFO is not full, or a pop occurs at the same edge: push.
- Otherwise: drop the record; drop_count++, saturating at all-ones. Dropped records still consume a seq, so the consumer sees gaps.

FIFO:
- Show-ahead. trace_rec is the head entry and is valid while trace_valid is high.
- Pop at an edge with trace_valid && trace_ready.
- Latency: a push at edge E into an empty FIFO gives trace_valid = 1 in the cycle after E.
- trace_rec stays stable while trace_valid && !trace_ready.
- Push and pop at the same edge: level unchanged, including when full (the pop frees the slot) and when level is 1.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_level = wr_cnt - rd_cnt, using extra-bit counters.

Output mux:
- trace_rec is 0 whenever trace_valid is low.

Decomposition:
- types.svh: trace_record_t packed struct {addr_t pc; instr_t instr; logic[4:0] rd; data_t rd_wdata; logic rd_we; addr_t mem_addr; data_t mem_wdata; logic[3:0] mem_be; logic[31:0] seq;}.
- params.svh: FSM state encodings as named localparams (FETCH, DECODE, FETCH_WAIT and the rest), shared with the control FSM and the logger.
- Sub-module: trace_fifo, a generic show-ahead synchronous FIFO parameterised by width and DEPTH. It exposes full, empty and level.

Test Plan:
1. addi x5,x0,7 at PC 0x00000010: DECODE → EXECUTEI → ALUWB (reg_write, rd=5, result=7) → FETCH, with trace_ready=1. Expect one record {pc=0x10, instr=0x00700293, rd=5, rd_wdata=7, rd_we=1, mem_be=0, seq=0}, with trace_valid high for exactly one cycle, the cycle after the FETCH edge.
2. sw with mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_we=4'hF. Expect rd_we=0, mem_be=4'hF, mem_addr=0x100, mem_wdata=0xDEADBEEF.
3. DEPTH=4, trace_ready=0, six retirements. Then:
   - Expect fifo_level=4, drop_count=2, retire_count=6.
   - After releasing trace_ready, expect records with seq 0,1,2,3 to drain.
   - Expect trace_valid=0 after the 4th pop.
4. FIFO full, and a retire edge coincides with trace_valid && trace_ready. Expect a push, level stays 4, drop_count unchanged, and the new record appears last.
5. Assert rst_n low during EXECUTER after DECODE. Expect all outputs 0. After release, a FETCH entry without a preceding DECODE produces no record; the next full instruction yields seq=0.
6. reg_write with rd=0, result=0x55. Expect rd_we=0 in the record. Separately, two consecutive FETCH/FETCH_WAIT cycles produce no spurious retire.
